// File: rtl/matrix_key_scan.sv
// 4x4 key matrix scanner: row drive, column sync, 16-key debounce and
// single-cycle press events with a {row,col} key code.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   row[3:0]   row drive, active-low one-hot
//   col[3:0]   column sense, active-low, asynchronous
//   key_valid  one-cycle pulse per accepted key press
//   key_code   code of the last reported key, {row_idx, col_idx}
//   key_down   high while the debounced image has a pressed key
module matrix_key_scan #(
   parameter int SCAN_DIV   = 50000,
   parameter int DEBOUNCE_N = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [3:0] row,
   input  logic [3:0] col,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_down
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_N + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_N);

   typedef enum logic {
      S_RELEASED,
      S_PRESSED
   } state_t;

   logic [3:0]    r_sync1;
   logic [3:0]    r_col_s;
   logic [DW-1:0] r_div_cnt;
   logic [1:0]    r_row_idx;
   logic [15:0]   r_frame;
   logic [15:0]   r_last_frame;
   logic [CW-1:0] r_stable_cnt;
   state_t        r_state;
   logic          r_key_valid;
   logic [3:0]    r_key_code;

   logic          w_tick;
   logic          w_frame_done;
   logic [15:0]   w_frame_next;
   logic [CW-1:0] w_cnt_next;
   logic          w_stable;
   logic          w_any;
   logic          w_single;
   logic [3:0]    w_idx;
   state_t        w_state_next;
   logic          w_fire;

   // Two-flop synchronizer; idles high like the pulled-up columns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 4'hF;
         r_col_s <= 4'hF;
      end else begin
         r_sync1 <= col;
         r_col_s <= r_sync1;
      end
   end

   assign w_tick       = (r_div_cnt == DIV_LAST);
   assign w_frame_done = w_tick && (r_row_idx == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt <= '0;
         r_row_idx <= 2'd0;
      end else if (w_tick) begin
         r_div_cnt <= '0;
         r_row_idx <= r_row_idx + 2'd1;
      end else begin
         r_div_cnt <= r_div_cnt + DW'(1);
      end
   end

   assign row = ~(4'b0001 << r_row_idx);

   // Frame image with the current row's nibble replaced by this slot's
   // sample; on the row-3 tick this is the completed frame.
   always_comb begin
      w_frame_next = r_frame;
      w_frame_next[{r_row_idx, 2'b00} +: 4] = ~r_col_s;
   end

   always_comb begin
      if (w_frame_next == r_last_frame) begin
         w_cnt_next = (r_stable_cnt == CNT_MAX) ?
                      CNT_MAX : r_stable_cnt + CW'(1);
      end else begin
         w_cnt_next = CW'(1);
      end
   end

   assign w_stable = w_frame_done && (w_cnt_next == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame      <= '0;
         r_last_frame <= '0;
         r_stable_cnt <= '0;
      end else begin
         if (w_tick) begin
            r_frame <= w_frame_next;
         end
         if (w_frame_done) begin
            r_last_frame <= w_frame_next;
            r_stable_cnt <= w_cnt_next;
         end
      end
   end

   // Exactly-one-bit test: clearing the lowest set bit leaves zero.
   assign w_any    = |w_frame_next;
   assign w_single = w_any &&
                     ((w_frame_next & (w_frame_next - 16'd1)) == 16'd0);

   // Bit index equals {row_idx, col_idx} because nibble r holds row r.
   always_comb begin
      w_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (w_frame_next[i]) w_idx = 4'(i);
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_fire       = 1'b0;
      if (w_stable) begin
         unique case (r_state)
            S_RELEASED: begin
               if (w_any) w_state_next = S_PRESSED;
               w_fire = w_single;
            end
            S_PRESSED: begin
               if (!w_any) w_state_next = S_RELEASED;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_RELEASED;
         r_key_valid <= 1'b0;
         r_key_code  <= 4'd0;
      end else begin
         r_state     <= w_state_next;
         r_key_valid <= w_fire;
         if (w_fire) r_key_code <= w_idx;
      end
   end

   assign key_valid = r_key_valid;
   assign key_code  = r_key_code;
   assign key_down  = (r_state == S_PRESSED);

endmodule

// File: doc/matrix_key_scan.md
# matrix_key_scan

Scanner for the clock's 4x4 push-button matrix: drives one row low at a time, reads back the active-low column lines, debounces the full 16-key image and emits one single-cycle event per key press with a 4-bit key code. It is the input-side counterpart of the multiplexed seven-segment display scan. Its events feed the mode and digit-calibration control logic.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each row is held active. Must be ≥ 4. The default gives 1 ms per row at 50 MHz.
- `DEBOUNCE_N`, default 5: number of consecutive identical frames required before a key image is accepted. Must be ≥ 1.
- `clk`, input, 1 bit: system clock. This is the only clock.
- `rst_n`, input, 1 bit: reset, asynchronous and active-low.
- `row`, output, 4 bits: row drive, active-low one-hot.
- `col`, input, 4 bits: column sense, asynchronous and active-low (pulled up externally).
- `key_valid`, output, 1 bit: single-cycle pulse that marks a new accepted key press.
- `key_code`, output, 4 bits: code of the last reported key, equal to `{row_idx, col_idx}`. Holds its value between events.
- `key_down`, output, 1 bit: high while the debounced image contains at least one pressed key.

## Operation
- **Column sync:** `col` passes through a 2-flop synchronizer. All logic uses the synchronized value, `col_s`.
- **Divider:** `div_cnt` counts 0..SCAN_DIV-1 and wraps. The cycle where `div_cnt == SCAN_DIV-1` is the slot end, `tick`.
- **Row driver:**
  - `row_idx` is 2 bits and advances 0→1→2→3→0 on `tick`.
  - `row = ~(4'b0001 << row_idx)`.
- **Sampling:**
  - At `tick`, `~col_s` is written into frame nibble `row_idx` (bits `[4*row_idx+3 : 4*row_idx]`), before the row advances.
  - A frame is complete at the `tick` where `row_idx == 3`.
- **Debounce, on each frame completion:**
  - If the new frame equals `last_frame`, `stable_cnt` increments, saturating at DEBOUNCE_N.
  - Otherwise `stable_cnt` is set to 1.
  - `last_frame` is set to the new frame.
  - The frame is "stable" when the updated `stable_cnt == DEBOUNCE_N`.
- **FSM:** two states, RELEASED and PRESSED. It is evaluated only on a frame completion that is stable.
  - RELEASED, exactly one bit set: go to PRESSED; pulse `key_valid`; load `key_code` with the bit index (`row_idx*4 + col_idx`).
  - RELEASED, two or more bits set: go to PRESSED with no event (ghost/multi-key lockout).
  - RELEASED, zero bits set: stay.
  - PRESSED, zero bits set: go to RELEASED.
  - PRESSED, any bits set: stay. Rolling onto another key or releasing one of two keys produces no event.
- `key_down` = (state == PRESSED).
- **Auto-repeat:** none. A key must be released and stably read as all-clear before the next event.

## Timing
- **Reset values:**
  - `row = 4'b1110`, `key_valid = 0`, `key_code = 0`, `key_down = 0`.
  - `div_cnt = 0`, `row_idx = 0`, `stable_cnt = 0`, `last_frame = 0`, frame register = 0, synchronizer = 2'b11 per bit, state = RELEASED.
- **Row hold:** each row is driven for exactly SCAN_DIV cycles. The frame period is 4*SCAN_DIV cycles.
- **Sample point:** the last cycle of a row slot. The synchronized value then reflects `col` from 2 cycles earlier, which is still within the same slot because SCAN_DIV ≥ 4.
- **Event latency:** `key_valid` and the new `key_code` are registered outputs. They appear on the cycle after the row-3 `tick` that completes the DEBOUNCE_N-th identical frame. `key_valid` is high for exactly 1 cycle.
- **Press visibility:** a press fully visible from the start of a frame is reported after DEBOUNCE_N frames, plus 1 cycle.
- **Glitches:** a bounce shorter than one frame breaks the stable run (`stable_cnt` back to 1) and delays the event. It never creates a second event.
- **Mid-operation reset:** asynchronous return to the reset values. No `key_valid` is generated by, or during, reset.
- **Wrap-around:**
  - `div_cnt` and `row_idx` wrap freely.
  - `stable_cnt` saturates, so a key held indefinitely never overflows or re-fires.

## Test plan
- **Reset and scan order** (SCAN_DIV=4, DEBOUNCE_N=3, no keys): `row` sequence is 1110, 1101, 1011, 0111, each held 4 cycles and repeating. `key_valid` stays 0 and `key_down` stays 0.
- **Single press:** pull `col[1]` low whenever `row == 1011`, starting at a frame boundary. Expect one `key_valid` pulse with `key_code = 4'd9`, 1 cycle after the end of the 3rd frame. `key_down` goes to 1. Holding for 20 more frames produces no further pulse.
- **Release and re-press:** release for ≥ 3 frames, then press row 0 / col 3. Expect `key_down` to fall after the 3rd clear frame, then a second pulse with `key_code = 4'd3`.
- **Bounce:** toggle the key every other frame for 6 frames, then hold. Expect no pulse during the toggling and exactly one pulse 3 frames after the hold begins.
- **Multi-key:** press keys 5 and 10 together, then release key 10. Expect no `key_valid` at any point and `key_down = 1` until both keys are released.
- **Mid-operation reset:** assert `rst_n = 0` while key 9 is held and `stable_cnt = 2`. Outputs return to their reset values immediately. After release of reset, the key is reported once, 3 frames later.
